// File: rtl/mem_access_unit_if.sv
// Data-side SRAM-like bus between mem_access_unit and memory.
// Request fields stay stable from data_req until data_addr_ok.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_wstrb,
        output data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_wstrb,
        input  data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: decode, alignment check, bus handshake, load extension.
// UNALIGNED_LWL_EN enables LWL/LWR/SWL/SWR (ops 9-12); otherwise they act as NONE.
module mem_access_unit #(
    parameter int ADDR_W      = 32,
    parameter int FLUSH_DRAIN = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic [3:0]        mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       writedata,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    input  logic              pipe_ready,
    output logic              stall,
    output logic [31:0]       result,
    output logic              result_valid,
    output logic              adel,
    output logic              ades,
    output logic [ADDR_W-1:0] bad_addr,
    mem_access_unit_if.master bus
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
`ifdef UNALIGNED_LWL_EN
    localparam logic [3:0] OP_LWL = 4'd9;
    localparam logic [3:0] OP_LWR = 4'd10;
    localparam logic [3:0] OP_SWL = 4'd11;
    localparam logic [3:0] OP_SWR = 4'd12;
`endif

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state;
    logic              discard;
    logic [3:0]        q_op;
    logic [1:0]        q_lo;
    logic              q_wr;
    logic [1:0]        q_size;
    logic [3:0]        q_strb;
    logic [ADDR_W-1:0] q_addr;
    logic [31:0]       q_wdata;
`ifdef UNALIGNED_LWL_EN
    logic [31:0]       q_rt;
`endif

    logic              d_ld, d_st, d_mis, d_word;
    logic [1:0]        d_size;
    logic [3:0]        d_strb;
    logic [31:0]       d_wdata;
    logic [ADDR_W-1:0] d_addr;
    logic [1:0]        lo;
    logic              launch, disc_set, drop;
    logic [31:0]       ext;
    logic [7:0]        bsel;
    logic [15:0]       hsel;

    assign lo = addr[1:0];

    always_comb begin
        d_ld    = 1'b0;
        d_st    = 1'b0;
        d_mis   = 1'b0;
        d_word  = 1'b0;
        d_size  = 2'b10;
        d_strb  = 4'b0000;
        d_wdata = writedata;
        case (mem_op)
            OP_LB, OP_LBU: begin
                d_ld   = 1'b1;
                d_size = 2'b00;
                d_strb = 4'b0001 << lo;
            end
            OP_LH, OP_LHU: begin
                d_ld   = 1'b1;
                d_size = 2'b01;
                d_strb = lo[1] ? 4'b1100 : 4'b0011;
                d_mis  = lo[0];
            end
            OP_LW: begin
                d_ld   = 1'b1;
                d_word = 1'b1;
                d_strb = 4'b1111;
                d_mis  = |lo;
            end
            OP_SB: begin
                d_st    = 1'b1;
                d_size  = 2'b00;
                d_strb  = 4'b0001 << lo;
                d_wdata = {4{writedata[7:0]}};
            end
            OP_SH: begin
                d_st    = 1'b1;
                d_size  = 2'b01;
                d_strb  = lo[1] ? 4'b1100 : 4'b0011;
                d_wdata = {2{writedata[15:0]}};
                d_mis   = lo[0];
            end
            OP_SW: begin
                d_st   = 1'b1;
                d_word = 1'b1;
                d_strb = 4'b1111;
                d_mis  = |lo;
            end
`ifdef UNALIGNED_LWL_EN
            OP_LWL, OP_LWR: begin
                d_ld   = 1'b1;
                d_word = 1'b1;
                d_strb = 4'b1111;
            end
            OP_SWL: begin
                d_st    = 1'b1;
                d_word  = 1'b1;
                d_strb  = 4'b1111 >> (2'd3 - lo);
                d_wdata = writedata >> {2'd3 - lo, 3'b000};
            end
            OP_SWR: begin
                d_st    = 1'b1;
                d_word  = 1'b1;
                d_strb  = 4'b1111 << lo;
                d_wdata = writedata << {lo, 3'b000};
            end
`endif
            default: ;
        endcase
        d_addr = d_word ? {addr[ADDR_W-1:2], 2'b00} : addr;
    end

    assign adel     = mem_valid & d_ld & d_mis;
    assign ades     = mem_valid & d_st & d_mis;
    assign bad_addr = (adel | ades) ? addr : pc;

    assign launch   = (state == S_IDLE) & mem_valid & (d_ld | d_st)
                    & ~d_mis & ~flush;
    assign disc_set = flush & (FLUSH_DRAIN != 0);
    assign drop     = discard | disc_set;
    assign stall    = launch | (state == S_REQ) | (state == S_WAIT);

    // Bus fields come from decode in the launch cycle, then from the latch.
    assign bus.data_req   = launch | (state == S_REQ);
    assign bus.data_wr    = launch ? d_st    : q_wr;
    assign bus.data_size  = launch ? d_size  : q_size;
    assign bus.data_wstrb = launch ? d_strb  : q_strb;
    assign bus.data_addr  = launch ? d_addr  : q_addr;
    assign bus.data_wdata = launch ? d_wdata : q_wdata;

    always_comb begin
        bsel = bus.data_rdata[{q_lo, 3'b000} +: 8];
        hsel = q_lo[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
        case (q_op)
            OP_LB:   ext = {{24{bsel[7]}}, bsel};
            OP_LBU:  ext = {24'd0, bsel};
            OP_LH:   ext = {{16{hsel[15]}}, hsel};
            OP_LHU:  ext = {16'd0, hsel};
            OP_LW:   ext = bus.data_rdata;
`ifdef UNALIGNED_LWL_EN
            OP_LWL:  ext = (bus.data_rdata << {2'd3 - q_lo, 3'b000})
                         | (q_rt & (32'h00FF_FFFF >> {q_lo, 3'b000}));
            OP_LWR:  ext = (bus.data_rdata >> {q_lo, 3'b000})
                         | (q_rt & ~(32'hFFFF_FFFF >> {q_lo, 3'b000}));
`endif
            default: ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            discard      <= 1'b0;
            result       <= 32'd0;
            result_valid <= 1'b0;
            q_op         <= 4'd0;
            q_lo         <= 2'd0;
            q_wr         <= 1'b0;
            q_size       <= 2'd0;
            q_strb       <= 4'd0;
            q_addr       <= '0;
            q_wdata      <= 32'd0;
`ifdef UNALIGNED_LWL_EN
            q_rt         <= 32'd0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    discard <= 1'b0;
                    if (launch) begin
                        q_op    <= mem_op;
                        q_lo    <= lo;
                        q_wr    <= d_st;
                        q_size  <= d_size;
                        q_strb  <= d_strb;
                        q_addr  <= d_addr;
                        q_wdata <= d_wdata;
`ifdef UNALIGNED_LWL_EN
                        q_rt    <= writedata;
`endif
                        state   <= bus.data_addr_ok ? S_WAIT : S_REQ;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (disc_set) discard <= 1'b1;
                    if (state == S_REQ && bus.data_addr_ok && !bus.data_data_ok)
                        state <= S_WAIT;
                    // Covers data_ok in WAIT and the same-cycle case in REQ.
                    if ((state == S_WAIT || bus.data_addr_ok) && bus.data_data_ok) begin
                        discard <= 1'b0;
                        if (drop) begin
                            state <= S_IDLE;
                        end else begin
                            result       <= ext;
                            result_valid <= 1'b1;
                            state        <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (flush || pipe_ready) begin
                        result_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with an expected-result queue.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_mem_access_unit;
    localparam logic [3:0] LB = 4'd1, LH = 4'd3, LHU = 4'd4, LW = 4'd5;
    localparam logic [3:0] SB = 4'd6, SH = 4'd7, SW = 4'd8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [3:0]  mem_op;
    logic [31:0] addr, writedata, pc;
    logic        flush, pipe_ready;
    logic        stall, result_valid, adel, ades;
    logic [31:0] result, bad_addr;

    int total = 0;
    int bad = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32), .FLUSH_DRAIN(1)) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_op(mem_op),
        .addr(addr), .writedata(writedata), .pc(pc), .flush(flush),
        .pipe_ready(pipe_ready), .stall(stall), .result(result),
        .result_valid(result_valid), .adel(adel), .ades(ades),
        .bad_addr(bad_addr), .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic take(input string tag);
        logic [31:0] e;
        chk({tag, "_rv"}, 32'(result_valid), 32'd1);
        chk({tag, "_sbq"}, 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_res"}, result, e);
        end
    endtask

    task automatic xfer(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int dly,
                        input logic [3:0] e_strb, input logic [31:0] e_wd,
                        input logic [31:0] e_addr, input logic [1:0] e_size,
                        input logic e_wr, input logic [31:0] e_res);
        @(negedge clk);
        mem_valid = 1'b1; mem_op = op; addr = a; writedata = wd;
        bus.data_addr_ok = (dly == 0); bus.data_data_ok = 1'b0;
        sb.push_back(e_res);
        #1;
        chk({tag, "_req"}, 32'(bus.data_req), 32'd1);
        chk({tag, "_strb"}, 32'(bus.data_wstrb), 32'(e_strb));
        chk({tag, "_wdata"}, bus.data_wdata, e_wd);
        chk({tag, "_addr"}, bus.data_addr, e_addr);
        chk({tag, "_size"}, 32'(bus.data_size), 32'(e_size));
        chk({tag, "_wr"}, 32'(bus.data_wr), 32'(e_wr));
        chk({tag, "_stall0"}, 32'(stall), 32'd1);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            bus.data_addr_ok = (i == dly - 1);
            #1;
            chk({tag, "_hold_req"}, 32'(bus.data_req), 32'd1);
            chk({tag, "_hold_addr"}, bus.data_addr, e_addr);
            chk({tag, "_hold_strb"}, 32'(bus.data_wstrb), 32'(e_strb));
            chk({tag, "_hold_stall"}, 32'(stall), 32'd1);
        end
        @(negedge clk);
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
        bus.data_rdata = rd;
        #1;
        chk({tag, "_wait_req"}, 32'(bus.data_req), 32'd0);
        chk({tag, "_wait_stall"}, 32'(stall), 32'd1);
        @(negedge clk);
        bus.data_data_ok = 1'b0;
        #1;
        take(tag);
        chk({tag, "_done_stall"}, 32'(stall), 32'd0);
        pipe_ready = 1'b1; mem_valid = 1'b0;
        @(negedge clk);
        pipe_ready = 1'b0;
        #1;
        chk({tag, "_idle_rv"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; mem_valid = 1'b0; mem_op = 4'd0;
        addr = 32'd0; writedata = 32'd0; pc = 32'd0;
        flush = 1'b0; pipe_ready = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
        bus.data_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_adel", 32'(adel), 32'd0);
        chk("rst_ades", 32'(ades), 32'd0);
        chk("rst_bad", bad_addr, 32'd0);
        chk("rst_req", 32'(bus.data_req), 32'd0);
        chk("rst_wr", 32'(bus.data_wr), 32'd0);
        chk("rst_strb", 32'(bus.data_wstrb), 32'd0);
        chk("rst_daddr", bus.data_addr, 32'd0);
        resetn = 1'b1;

        xfer("lb", LB, 32'h0000_1003, 32'd0, 32'h80FF_FF7F, 0,
             4'b1000, 32'd0, 32'h0000_1003, 2'b00, 1'b0, 32'hFFFF_FF80);
        xfer("sh", SH, 32'h0000_2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 0,
             4'b1100, 32'hABCD_ABCD, 32'h0000_2002, 2'b01, 1'b1, 32'd0);
        xfer("sb", SB, 32'h0000_2001, 32'h0000_00A5, 32'd0, 1,
             4'b0010, 32'hA5A5_A5A5, 32'h0000_2001, 2'b00, 1'b1, 32'd0);
        xfer("lhu", LHU, 32'h0000_4002, 32'd0, 32'h8001_5555, 3,
             4'b1100, 32'd0, 32'h0000_4002, 2'b01, 1'b0, 32'h0000_8001);
        xfer("lh", LH, 32'h0000_4000, 32'd0, 32'h1234_F00D, 1,
             4'b0011, 32'd0, 32'h0000_4000, 2'b01, 1'b0, 32'hFFFF_F00D);

        // Address errors
        @(negedge clk);
        mem_valid = 1'b1; mem_op = LW; addr = 32'h0000_3006;
        pc = 32'h0000_0400;
        #1;
        chk("lw_adel", 32'(adel), 32'd1);
        chk("lw_ades", 32'(ades), 32'd0);
        chk("lw_bad", bad_addr, 32'h0000_3006);
        chk("lw_req", 32'(bus.data_req), 32'd0);
        chk("lw_stall", 32'(stall), 32'd0);
        @(negedge clk);
        #1;
        chk("lw_req2", 32'(bus.data_req), 32'd0);
        mem_op = SW; addr = 32'h0000_3001;
        #1;
        chk("sw_ades", 32'(ades), 32'd1);
        chk("sw_adel", 32'(adel), 32'd0);
        chk("sw_bad", bad_addr, 32'h0000_3001);
        mem_op = LH; addr = 32'h0000_3002; mem_valid = 1'b0;
        #1;
        chk("ok_bad_pc", bad_addr, 32'h0000_0400);
        mem_op = LW; addr = 32'h0000_3003;
        #1;
        chk("inv_adel", 32'(adel), 32'd0);

        // Flush while waiting for data: drained with no result
        @(negedge clk);
        mem_valid = 1'b1; mem_op = LW; addr = 32'h0000_5000;
        bus.data_addr_ok = 1'b1;
        #1;
        chk("fl_req", 32'(bus.data_req), 32'd1);
        @(negedge clk);
        bus.data_addr_ok = 1'b0; flush = 1'b1; mem_valid = 1'b0;
        #1;
        chk("fl_stall_w", 32'(stall), 32'd1);
        @(negedge clk);
        flush = 1'b0; bus.data_data_ok = 1'b1;
        bus.data_rdata = 32'h1111_1111;
        #1;
        chk("fl_stall_d", 32'(stall), 32'd1);
        @(negedge clk);
        bus.data_data_ok = 1'b0;
        #1;
        chk("fl_rv", 32'(result_valid), 32'd0);
        chk("fl_stall", 32'(stall), 32'd0);
        chk("fl_req2", 32'(bus.data_req), 32'd0);
        xfer("lw_after", LW, 32'h0000_5004, 32'd0, 32'hDEAD_BEEF, 0,
             4'b1111, 32'd0, 32'h0000_5004, 2'b10, 1'b0, 32'hDEAD_BEEF);

        // Same-cycle addr_ok/data_ok, hold in DONE, flush in DONE
        @(negedge clk);
        mem_valid = 1'b1; mem_op = LB; addr = 32'h0000_6001;
        #1;
        chk("sc_req", 32'(bus.data_req), 32'd1);
        @(negedge clk);
        bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1;
        bus.data_rdata = 32'h0000_7F00;
        sb.push_back(32'h0000_007F);
        #1;
        chk("sc_stall", 32'(stall), 32'd1);
        @(negedge clk);
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
        #1;
        take("sc");
        chk("sc_stall_done", 32'(stall), 32'd0);
        @(negedge clk);
        #1;
        chk("sc_hold_rv", 32'(result_valid), 32'd1);
        chk("sc_hold_res", result, 32'h0000_007F);
        chk("sc_no_reissue", 32'(bus.data_req), 32'd0);
        flush = 1'b1; mem_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("sc_flush_rv", 32'(result_valid), 32'd0);

`ifdef UNALIGNED_LWL_EN
        xfer("lwl", 4'd9, 32'h0000_8001, 32'h1122_3344, 32'hAABB_CCDD, 0,
             4'b1111, 32'h1122_3344, 32'h0000_8000, 2'b10, 1'b0,
             32'hCCDD_3344);
        xfer("swr", 4'd12, 32'h0000_8002, 32'h1122_3344, 32'd0, 0,
             4'b1100, 32'h3344_0000, 32'h0000_8000, 2'b10, 1'b1, 32'd0);
`else
        @(negedge clk);
        mem_valid = 1'b1; mem_op = 4'd9; addr = 32'h0000_8001;
        #1;
        chk("lwl_off_req", 32'(bus.data_req), 32'd0);
        chk("lwl_off_adel", 32'(adel), 32'd0);
        chk("lwl_off_stall", 32'(stall), 32'd0);
        mem_valid = 1'b0;
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the M-stage combinational byte-select logic.
- Decodes load/store ops, checks alignment, and raises address-error exceptions.
- Drives an SRAM-like request/handshake data bus (req / addr_ok / data_ok) and stalls the pipeline until the access completes.
- Returns the sign/zero-extended load result, held stable until the next stage accepts it.

Parameters:
- ADDR_W, 32: width of address, pc and bad_addr.
- FLUSH_DRAIN, 1: 1 = a flushed in-flight access still waits for its data_ok before IDLE; 0 is illegal (reserved).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  M-stage instruction valid
- mem_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LWL, 10 LWR, 11 SWL, 12 SWR
- addr  in  ADDR_W  effective address (aluoutM)
- writedata  in  32  store source register
- pc  in  ADDR_W  pc of M-stage instruction
- flush  in  1  exception/eret flush of M stage
- pipe_ready  in  1  W stage accepts result this cycle
- stall  out  1  hold F..M stages
- result  out  32  extended load data
- result_valid  out  1  result is valid
- adel / ades  out  1  load / store address error
- bad_addr  out  ADDR_W  addr on error, else pc
- data_req, data_wr  out  1  bus request, write
- data_size  out  2  00 byte, 01 half, 10 word
- data_wstrb  out  4  byte strobes
- data_addr  out  ADDR_W  word-aligned for word ops, else addr
- data_wdata  out  32  replicated store data
- data_addr_ok, data_data_ok  in  1  bus handshakes
- data_rdata  in  32  read data

Behaviour:
- Reset (resetn low, async): state IDLE. All outputs 0, except bad_addr = 0. result register cleared.
- Decode (combinational, every cycle):
  - Strobes: LB/SB at addr[1:0] = k give wstrb/sel = 1 << k. LH/SH at 00 give 0011, at 10 give 1100. LW/SW give 1111.
  - Store data: SB replicates writedata[7:0] x4; SH replicates [15:0] x2.
  - Misalignment: LH/LHU with addr[0]=1, or LW with addr[1:0] != 0, sets adel. SH/SW with the same conditions sets ades. On error, bad_addr = addr.
- Errors: adel/ades are combinational and valid only while mem_valid. An erroring op issues no bus request and raises no stall.
- FSM:
  - IDLE: mem_valid & op != NONE & no error & !flush -> REQ, with data_req=1 in the same cycle. stall=1.
  - REQ: data_req held with constant addr/size/wstrb/wdata until data_addr_ok -> WAIT. Request is never withdrawn, even on flush.
  - WAIT: on data_data_ok, latch the extended data_rdata into result (0 for stores). Then go to DONE, or to IDLE if the discard flag is set.
  - DONE: result_valid=1, stall=0. pipe_ready -> IDLE. A new request cannot issue from DONE; it waits for IDLE.
- stall = (state in REQ or WAIT) | (IDLE & request launching).
- Same-cycle handshakes: addr_ok and data_ok in the same cycle while in REQ -> go directly to DONE or IDLE, with data captured.
- Flush: in REQ or WAIT, set the discard flag; the access is drained with no result_valid. The flag clears on return to IDLE. Flush in DONE -> IDLE, result dropped.
- Load extension: LB/LH sign-extend and LBU/LHU zero-extend the byte/half selected by addr[1:0]. LW is passthrough.
- Latency: a load with addr_ok and data_ok on consecutive cycles has result_valid 2 cycles after issue.

Optional Feature:
- Macro UNALIGNED_LWL_EN.
- Defined:
  - Ops 9-12 are legal and never raise adel/ades.
  - data_addr = addr & ~3, data_size = 10.
  - LWL/LWR merge data_rdata with writedata (old rt) per MIPS32 little-endian rules.
  - SWL wstrb by addr[1:0] = 00:0001, 01:0011, 10:0111, 11:1111. SWR wstrb = 1111, 1110, 1100, 1000. Data is shifted accordingly.
- Undefined: ops 9-12 are treated as NONE, with no request and no exception.

Test Plan:
- LB addr=0x...3, rdata=0x80FF_FF7F, immediate handshakes -> wstrb 1000, result=0xFFFF_FF80, result_valid 2 cycles after issue.
- SH addr=0x...2, writedata=0x1234_ABCD -> data_wdata=0xABCD_ABCD, wstrb=1100, data_wr=1, result=0.
- LW addr=0x...6 -> adel=1, bad_addr=addr, data_req never asserted, stall=0.
- LHU addr=0x...2 with addr_ok delayed 3 cycles -> req and address stable throughout, stall high until data_ok, then result=0x0000_8001 for rdata=0x8001_xxxx.
- Flush in WAIT, then data_ok -> no result_valid, FSM back in IDLE; the next LW issues normally.
- With UNALIGNED_LWL_EN: LWL addr=0x...1, rdata=0xAABB_CCDD, rt=0x1122_3344 -> result=0xCCDD_3344.
